// File: rtl/binop_vector_seq.sv
// binop_vector_seq: stimulus/response checker around a 1-bit binary-operator DUT.
// It issues vector k as a = k[0], b = k[1], and it compares y against OP(a, b)
// through an alignment pipeline that is LATENCY+1 deep.
// Optional feature macro: BINOP_SEQ_ERR_CNT_EN. When it is defined, the checker
// runs to completion and counts mismatches. When it is undefined, the checker
// stops at the first mismatch and err_count is tied to 0.
module binop_vector_seq #(
  parameter int unsigned NUM_VEC = 4,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned OP      = 0
) (
  input  logic        clock,
  input  logic        reset,
  output logic        a,
  output logic        b,
  input  logic        y,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [15:0] fail_idx,
  output logic [7:0]  err_count
);

  localparam logic [15:0] LastIdx = 16'(NUM_VEC - 1);
`ifdef BINOP_SEQ_ERR_CNT_EN
  localparam bit StopOnFail = 1'b0;
`else
  localparam bit StopOnFail = 1'b1;
`endif

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StFin} state_e;

  state_e           state_q, state_d;
  logic [15:0]      launch_idx_q, launch_idx_d;
  logic [15:0]      cmp_idx_q, cmp_idx_d;
  logic             a_q, a_d, b_q, b_d;
  logic [LATENCY:0] exp_pipe_q, vld_pipe_q;
  logic             push_exp, push_vld;
  logic             done_q, done_d, pass_q, pass_d, fail_q, fail_d;
  logic [15:0]      fail_idx_q, fail_idx_d;
  logic [7:0]       err_q, err_d;
  logic             cmp_vld, mismatch, last_launch, last_cmp, stop_now, launch, fin_now;

  function automatic logic op_fn(logic x, logic z);
    case (OP)
      0:       return x ^ z;
      1:       return x & z;
      2:       return x | z;
      default: return ~(x ^ z);
    endcase
  endfunction

  // Decode the comparison point at the tail of the alignment pipeline.
  always_comb begin
    cmp_vld     = vld_pipe_q[LATENCY] && (state_q == StRun || state_q == StDrain);
    // The case inequality makes an X or Z on y count as a mismatch in simulation.
    mismatch    = cmp_vld && (y !== exp_pipe_q[LATENCY]);
    last_launch = (launch_idx_q == LastIdx);
    last_cmp    = cmp_vld && (cmp_idx_q == LastIdx);
    stop_now    = StopOnFail && mismatch;
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      // Vector 0 launches on the first edge out of reset.
      StIdle:  state_d = last_launch ? StDrain : StRun;
      StRun: begin
        if (stop_now)         state_d = StFin;
        else if (last_launch) state_d = StDrain;
      end
      StDrain: if (stop_now || last_cmp) state_d = StFin;
      StFin:   state_d = StFin;
      default: state_d = StIdle;
    endcase
  end

  // Output and datapath next-state logic.
  always_comb begin
    launch       = (state_q == StIdle) || (state_q == StRun && !stop_now);
    a_d          = launch & launch_idx_q[0];
    b_d          = launch & launch_idx_q[1];
    push_vld     = launch;
    push_exp     = launch & op_fn(launch_idx_q[0], launch_idx_q[1]);
    launch_idx_d = launch ? launch_idx_q + 16'd1 : launch_idx_q;
    // Results return in launch order, so the count of comparisons is the vector index.
    cmp_idx_d    = cmp_vld ? cmp_idx_q + 16'd1 : cmp_idx_q;
    fin_now      = (state_d == StFin) && (state_q != StFin);
    fail_d       = fail_q | mismatch;
    fail_idx_d   = (mismatch && !fail_q) ? cmp_idx_q : fail_idx_q;
    done_d       = done_q | fin_now;
    pass_d       = pass_q | (fin_now & ~fail_d);
`ifdef BINOP_SEQ_ERR_CNT_EN
    err_d        = (mismatch && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
`else
    err_d        = 8'd0;
`endif
  end

  // Datapath and status registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      launch_idx_q <= '0;
      cmp_idx_q    <= '0;
      a_q          <= 1'b0;
      b_q          <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_idx_q   <= '0;
      err_q        <= '0;
    end else begin
      launch_idx_q <= launch_idx_d;
      cmp_idx_q    <= cmp_idx_d;
      a_q          <= a_d;
      b_q          <= b_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      fail_idx_q   <= fail_idx_d;
      err_q        <= err_d;
    end
  end

  if (LATENCY == 0) begin : g_pipe_single
    // Alignment pipeline with a single stage.
    always_ff @(posedge clock) begin
      if (reset) begin
        exp_pipe_q <= '0;
        vld_pipe_q <= '0;
      end else begin
        exp_pipe_q <= push_exp;
        vld_pipe_q <= push_vld;
      end
    end
  end else begin : g_pipe_multi
    // Alignment pipeline that shifts toward the comparison point.
    always_ff @(posedge clock) begin
      if (reset) begin
        exp_pipe_q <= '0;
        vld_pipe_q <= '0;
      end else begin
        exp_pipe_q <= {exp_pipe_q[LATENCY-1:0], push_exp};
        vld_pipe_q <= {vld_pipe_q[LATENCY-1:0], push_vld};
      end
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign fail_idx  = fail_idx_q;
  assign err_count = err_q;

endmodule
